stage_decode: RTL

- Decode stage plus D/X pipeline register. Sits between the F/D latch and the execute stage.
- Splits the fetched instruction into fields and drives the register file read ports, with a write-back bypass on the read data.
- Detects load-use hazards and inserts bubbles. Squashes on redirect from execute.
- Every execute-stage input (opcode, ALU_op, shamt, immediate, target, operands, pc_plus_4, pc_upper_5) is a registered output of this block.

---
 rtl/stage_decode_pkg.sv | 45 ++++
 rtl/stage_decode_hazard.sv | 58 +++++
 rtl/stage_decode.sv | 121 ++++++++++++
 3 files changed

// File: rtl/stage_decode_pkg.sv
// Shared decode definitions: opcodes, instruction field positions and the D/X register layout.
// Zero latency; no flow control of its own.
package stage_decode_pkg;

  localparam logic [4:0] OP_R    = 5'b00000;
  localparam logic [4:0] OP_J    = 5'b00001;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_SETX = 5'b10101;
  localparam logic [4:0] OP_BEX  = 5'b10110;

  localparam int OPC_LSB   = 27;
  localparam int RD_LSB    = 22;
  localparam int RS_LSB    = 17;
  localparam int RT_LSB    = 12;
  localparam int SHAMT_LSB = 7;
  localparam int ALU_LSB   = 2;

  typedef struct packed {
    logic        vld;
    logic [4:0]  opcode;
    logic [4:0]  alu_op;
    logic [4:0]  shamt;
    logic [16:0] imm;
    logic [26:0] target;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] pc_plus_4;
    logic [4:0]  pc_upper_5;
    logic [4:0]  rd;
  } dx_t;

  // A bubble is add $0,$0,$0 with no valid bit and no PC.
  localparam dx_t DX_BUBBLE = '0;

  function automatic logic [4:0] field5(input logic [31:0] insn, input int lsb);
    return insn[lsb +: 5];
  endfunction

endpackage

// File: rtl/stage_decode_hazard.sv
// Combinational decode of read ports, destination register and load-use hazard.
// Zero latency; hazard output is the backpressure request toward fetch.
module decode_hazard
  import stage_decode_pkg::*;
#(
  parameter int REG_STATUS = 30,
  parameter int REG_RA     = 31
) (
  input  logic       fd_valid,
  input  logic [4:0] op,
  input  logic [4:0] rd,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       dx_valid,
  input  logic [4:0] dx_opcode,
  input  logic [4:0] dx_rd,
  output logic [4:0] read_a,
  output logic [4:0] read_b,
  output logic [4:0] dest,
  output logic       hazard
);

  localparam logic [4:0] STATUS_IDX = 5'(REG_STATUS);
  localparam logic [4:0] RA_IDX     = 5'(REG_RA);

  logic use_a;
  logic use_b;

  always_comb begin
    read_a = (op == OP_BEX) ? STATUS_IDX : rs;
    use_a  = op inside {OP_R, OP_ADDI, OP_LW, OP_SW, OP_BNE, OP_BLT, OP_BEX};

    read_b = '0;
    use_b  = 1'b0;
    case (op)
      OP_R: begin
        read_b = rt;
        use_b  = 1'b1;
      end
      OP_BNE, OP_BLT, OP_JR, OP_SW: begin
        read_b = rd;
        use_b  = 1'b1;
      end
      default: ;
    endcase

    case (op)
      OP_R, OP_ADDI, OP_LW: dest = rd;
      OP_JAL:               dest = RA_IDX;
      OP_SETX:              dest = STATUS_IDX;
      default:              dest = '0;
    endcase

    hazard = dx_valid && (dx_opcode == OP_LW) && (dx_rd != '0) && fd_valid &&
             ((use_a && (read_a == dx_rd)) || (use_b && (read_b == dx_rd)));
  end

endmodule

// File: rtl/stage_decode.sv
// Decode stage with D/X pipeline register, write-back bypass and load-use bubble insertion.
// One cycle F/D to execute; stall_in freezes D/X, load-use hazards freeze F/D via stall_fd.
module stage_decode
  import stage_decode_pkg::*;
#(
  parameter int REG_STATUS = 30,
  parameter int REG_RA     = 31,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             fd_valid,
  input  logic [31:0]      fd_insn,
  input  logic [31:0]      fd_pc_plus_4,
  input  logic             stall_in,
  input  logic             flush,
  input  logic             wb_en,
  input  logic [4:0]       wb_reg,
  input  logic [31:0]      wb_data,
  output logic [4:0]       ctrl_readRegA,
  output logic [4:0]       ctrl_readRegB,
  input  logic [31:0]      data_readRegA,
  input  logic [31:0]      data_readRegB,
  output logic             stall_fd,
  output logic             dx_valid,
  output logic [4:0]       opcode,
  output logic [4:0]       ALU_op,
  output logic [4:0]       shamt,
  output logic [16:0]      immediate,
  output logic [26:0]      target,
  output logic [31:0]      regfile_operandA,
  output logic [31:0]      regfile_operandB,
  output logic [31:0]      pc_plus_4,
  output logic [4:0]       pc_upper_5,
  output logic [4:0]       dx_rd,
  output logic [CNT_W-1:0] stall_count
);

  logic [4:0]       f_op, f_rd, f_rs, f_rt;
  logic [4:0]       dest;
  logic             hazard;
  logic [31:0]      opnd_a, opnd_b;
  dx_t              dx_d, dx_q;
  logic [CNT_W-1:0] cnt_q;

  assign f_op = field5(fd_insn, OPC_LSB);
  assign f_rd = field5(fd_insn, RD_LSB);
  assign f_rs = field5(fd_insn, RS_LSB);
  assign f_rt = field5(fd_insn, RT_LSB);

  decode_hazard #(
    .REG_STATUS (REG_STATUS),
    .REG_RA     (REG_RA)
  ) u_hazard (
    .fd_valid  (fd_valid),
    .op        (f_op),
    .rd        (f_rd),
    .rs        (f_rs),
    .rt        (f_rt),
    .dx_valid  (dx_q.vld),
    .dx_opcode (dx_q.opcode),
    .dx_rd     (dx_q.rd),
    .read_a    (ctrl_readRegA),
    .read_b    (ctrl_readRegB),
    .dest      (dest),
    .hazard    (hazard)
  );

  // $0 is never bypassed so it always reads as the register file's hardwired zero.
  assign opnd_a = (wb_en && (wb_reg == ctrl_readRegA) && (ctrl_readRegA != '0)) ? wb_data : data_readRegA;
  assign opnd_b = (wb_en && (wb_reg == ctrl_readRegB) && (ctrl_readRegB != '0)) ? wb_data : data_readRegB;

  always_comb begin
    dx_d            = DX_BUBBLE;
    dx_d.vld        = 1'b1;
    dx_d.opcode     = f_op;
    dx_d.alu_op     = field5(fd_insn, ALU_LSB);
    dx_d.shamt      = field5(fd_insn, SHAMT_LSB);
    dx_d.imm        = fd_insn[16:0];
    dx_d.target     = fd_insn[26:0];
    dx_d.op_a       = opnd_a;
    dx_d.op_b       = opnd_b;
    dx_d.pc_plus_4  = fd_pc_plus_4;
    dx_d.pc_upper_5 = fd_pc_plus_4[31:27];
    dx_d.rd         = dest;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dx_q  <= DX_BUBBLE;
      cnt_q <= '0;
    end else if (stall_in) begin
      dx_q  <= dx_q;
      cnt_q <= cnt_q;
    end else if (flush) begin
      dx_q  <= DX_BUBBLE;
    end else if (hazard) begin
      dx_q  <= DX_BUBBLE;
      if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
    end else begin
      dx_q  <= fd_valid ? dx_d : DX_BUBBLE;
    end
  end

  // A redirect squashes the consumer, so the hazard no longer needs to hold fetch.
  assign stall_fd = ~reset & (stall_in | (hazard & ~flush));

  assign dx_valid         = dx_q.vld;
  assign opcode           = dx_q.opcode;
  assign ALU_op           = dx_q.alu_op;
  assign shamt            = dx_q.shamt;
  assign immediate        = dx_q.imm;
  assign target           = dx_q.target;
  assign regfile_operandA = dx_q.op_a;
  assign regfile_operandB = dx_q.op_b;
  assign pc_plus_4        = dx_q.pc_plus_4;
  assign pc_upper_5       = dx_q.pc_upper_5;
  assign dx_rd            = dx_q.rd;
  assign stall_count      = cnt_q;

endmodule
